// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: ROM entry layout, op codes
// and FSM state encoding.
package spi_seq_pkg;

    localparam int ENTRY_W = 10;

    typedef enum logic [1:0] {
        OP_CMD  = 2'b00,
        OP_DATA = 2'b01,
        OP_DLY  = 2'b10,
        OP_END  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SEND   = 3'd2,
        WAIT_V = 3'd3,
        GAP    = 3'd4,
        DELAY  = 3'd5,
        FINISH = 3'd6
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] arg;
    } entry_t;

endpackage

// File: rtl/spi_seq_rom.sv
// Synchronous-read sequence ROM, one cycle of read latency. Contents come from
// a packed image parameter with entry 0 in the least significant bits.
module spi_seq_rom
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter logic [DEPTH*ENTRY_W-1:0] INIT = {DEPTH{10'h300}}
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output entry_t        q
);

    always_ff @(posedge clk) begin
        q <= entry_t'(INIT[32'(addr) * ENTRY_W +: ENTRY_W]);
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// Walks a ROM of command/data/delay/end entries and feeds bytes to a
// downstream SPI block one at a time, with a timeout on each byte handshake.
module spi_cmd_seq
    import spi_seq_pkg::*;
#(
    parameter int ROM_DEPTH  = 64,
    parameter int CLK_PER_MS = 100000,
    parameter int TIMEOUT    = 4096,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] ROM_INIT = {ROM_DEPTH{10'h300}}
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       spi_valid,
    output logic       spi_onoff,
    output logic [7:0] spi_data,
    output logic       dc,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int AW      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int DLY_MAX = 255 * CLK_PER_MS;
    localparam int CNT_MAX = (DLY_MAX > TIMEOUT) ? DLY_MAX : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              onoff_q, onoff_d;
    logic [7:0]        data_q, data_d;
    logic              dc_q, dc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    entry_t            rom_q;

    // The ROM is addressed with the next address so the entry is ready in FETCH.
    spi_seq_rom #(
        .DEPTH (ROM_DEPTH),
        .AW    (AW),
        .INIT  (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (addr_d),
        .q    (rom_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            onoff_q <= 1'b0;
            data_q  <= '0;
            dc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            onoff_q <= onoff_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        onoff_d = onoff_q;
        data_d  = data_q;
        dc_d    = dc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                case (rom_q.op)
                    OP_CMD, OP_DATA: begin
                        data_d  = rom_q.arg;
                        dc_d    = (rom_q.op == OP_DATA);
                        onoff_d = 1'b1;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                    OP_DLY: begin
                        cnt_d   = CNT_W'(32'(rom_q.arg) * CLK_PER_MS);
                        state_d = DELAY;
                    end
                    default: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end
                endcase
            end
            SEND: state_d = WAIT_V;
            WAIT_V: begin
                // cnt_q counts WAIT_V cycles already spent without a handshake.
                if (spi_valid) begin
                    onoff_d = 1'b0;
                    state_d = GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    onoff_d = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (addr_q == LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = FETCH;
                end
            end
            DELAY: begin
                // A zero-length delay still spends one cycle here.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign spi_onoff = onoff_q;
    assign spi_data  = data_q;
    assign dc        = dc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
